// File: rtl/imm_gen_pkg.sv
// Shared types and constants for the immediate-generation stage.
// Optional macro IMM_GEN_ZIMM_EN adds the CSR zero-extended immediate type (IMM_TYPE_Z).
package imm_gen_pkg;

    localparam int XLEN_32 = 32;
    localparam int XLEN_64 = 64;

    localparam int XLEN_DEFAULT = XLEN_64;

    // Stored entries are sized for the widest configuration; the top slices them down.
    localparam int IMM_MAX_W = 64;
    localparam int TAG_MAX_W = 64;

    typedef enum logic [2:0] {
        IMM_TYPE_NONE   = 3'd0,
        IMM_TYPE_I      = 3'd1,
        IMM_TYPE_S      = 3'd2,
        IMM_TYPE_B      = 3'd3,
        IMM_TYPE_U      = 3'd4,
        IMM_TYPE_J      = 3'd5,
`ifdef IMM_GEN_ZIMM_EN
        IMM_TYPE_ISHIFT = 3'd6,
        IMM_TYPE_Z      = 3'd7
`else
        IMM_TYPE_ISHIFT = 3'd6
`endif
    } immediate_type_e;

    typedef struct packed {
        logic [IMM_MAX_W-1:0] imm;
        logic [TAG_MAX_W-1:0] tag;
        logic                 err;
    } imm_entry_t;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction and sign extension for one instruction word.
// Optional macro IMM_GEN_ZIMM_EN enables the CSRRxI zero-extended immediate.
module imm_extract
    import imm_gen_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [31:0]      instr_i,
    input  immediate_type_e  imm_type_i,
    output logic [XLEN-1:0]  imm_o,
    output logic             err_o
);

    logic signed [31:0] imm32_p0;
    logic               err_p0;
    logic               unused_opcode;

    assign unused_opcode = ^instr_i[6:0];

    // Every format is first built as a 32-bit signed value; zero-extended formats keep bit 31 clear.
    always_comb begin
        imm32_p0 = '0;
        err_p0   = 1'b0;
        case (imm_type_i)
            IMM_TYPE_NONE: imm32_p0 = '0;
            IMM_TYPE_I:    imm32_p0 = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_TYPE_S:    imm32_p0 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_TYPE_B:    imm32_p0 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                                       instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_TYPE_U:    imm32_p0 = {instr_i[31:12], 12'h000};
            IMM_TYPE_J:    imm32_p0 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                                       instr_i[20], instr_i[30:21], 1'b0};
            IMM_TYPE_ISHIFT: begin
                if (XLEN == XLEN_32) begin
                    if (instr_i[25]) begin
                        err_p0 = 1'b1;
                    end else begin
                        imm32_p0 = {27'd0, instr_i[24:20]};
                    end
                end else begin
                    imm32_p0 = {26'd0, instr_i[25:20]};
                end
            end
`ifdef IMM_GEN_ZIMM_EN
            IMM_TYPE_Z:    imm32_p0 = {27'd0, instr_i[19:15]};
`endif
            default: begin
                imm32_p0 = '0;
                err_p0   = 1'b1;
            end
        endcase
    end

    assign imm_o = XLEN'(imm32_p0);
    assign err_o = err_p0;

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate-generation stage: extracts the immediate at push and queues {imm, tag, err}
// in a DEPTH-entry FIFO with valid/ready on both sides. Optional macro: IMM_GEN_ZIMM_EN.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int DEPTH = 2,
    parameter int TAG_W = 64
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        flush_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [31:0]                 instr_i,
    input  immediate_type_e             imm_type_i,
    input  logic [TAG_W-1:0]            tag_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [XLEN-1:0]             imm_o,
    output logic [TAG_W-1:0]            tag_o,
    output logic                        imm_err_o,
    output logic [$clog2(DEPTH+1)-1:0]  count_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [XLEN-1:0]  imm_p0;
    logic             err_p0;
    logic             vld_p0;
    logic             pop_p1;
    imm_entry_t       entry_p0;

    imm_entry_t       mem_p1 [DEPTH];
    imm_entry_t       head_p1;
    logic [PTR_W-1:0] wr_ptr_p1;
    logic [PTR_W-1:0] rd_ptr_p1;
    logic [CNT_W-1:0] count_p1;

    // Stage p0: extraction on the push path
    imm_extract #(
        .XLEN (XLEN)
    ) u_imm_extract (
        .instr_i    (instr_i),
        .imm_type_i (imm_type_i),
        .imm_o      (imm_p0),
        .err_o      (err_p0)
    );

    always_comb begin
        entry_p0     = '0;
        entry_p0.imm = IMM_MAX_W'(imm_p0);
        entry_p0.tag = TAG_MAX_W'(tag_i);
        entry_p0.err = err_p0;
    end

    // Readiness comes from the registered count only, so a full FIFO never accepts
    // even when the head retires in the same cycle.
    assign in_ready_o  = (count_p1 < DEPTH_C);
    assign out_valid_o = (count_p1 != '0);
    assign vld_p0      = in_valid_i && in_ready_o;
    assign pop_p1      = out_valid_o && out_ready_i;

    // Stage p1: FIFO storage and pointers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_p1 <= '0;
            rd_ptr_p1 <= '0;
            count_p1  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_p1[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr_p1 <= '0;
            rd_ptr_p1 <= '0;
            count_p1  <= '0;
        end else begin
            if (vld_p0) begin
                mem_p1[wr_ptr_p1] <= entry_p0;
                wr_ptr_p1         <= wr_ptr_p1 + PTR_W'(1);
            end
            if (pop_p1) begin
                rd_ptr_p1 <= rd_ptr_p1 + PTR_W'(1);
            end
            if (vld_p0 && !pop_p1) begin
                count_p1 <= count_p1 + CNT_W'(1);
            end else if (!vld_p0 && pop_p1) begin
                count_p1 <= count_p1 - CNT_W'(1);
            end
        end
    end

    assign head_p1   = mem_p1[rd_ptr_p1];
    assign imm_o     = head_p1.imm[XLEN-1:0];
    assign tag_o     = head_p1.tag[TAG_W-1:0];
    assign imm_err_o = head_p1.err;
    assign count_o   = count_p1;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: one XLEN=64 instance and one XLEN=32 instance.
// Honours IMM_GEN_ZIMM_EN for the type-7 encoding.
module tb_imm_gen_pipe;
    import imm_gen_pkg::*;

    typedef struct packed {
        logic [63:0] imm;
        logic [63:0] tag;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic            a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_err;
    logic [31:0]     a_instr;
    immediate_type_e a_type;
    logic [63:0]     a_tag, a_tag_o, a_imm;
    logic [1:0]      a_count;

    logic            b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_err;
    logic [31:0]     b_instr;
    immediate_type_e b_type;
    logic [63:0]     b_tag, b_tag_o;
    logic [31:0]     b_imm;
    logic [1:0]      b_count;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_pass  = 0;
    int   n_total = 0;

    imm_gen_pipe #(.XLEN(64), .DEPTH(2), .TAG_W(64)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(a_flush),
        .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
        .instr_i(a_instr), .imm_type_i(a_type), .tag_i(a_tag),
        .out_valid_o(a_out_valid), .out_ready_i(a_out_ready),
        .imm_o(a_imm), .tag_o(a_tag_o), .imm_err_o(a_err), .count_o(a_count)
    );

    imm_gen_pipe #(.XLEN(32), .DEPTH(2), .TAG_W(64)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(b_flush),
        .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
        .instr_i(b_instr), .imm_type_i(b_type), .tag_i(b_tag),
        .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
        .imm_o(b_imm), .tag_o(b_tag_o), .imm_err_o(b_err), .count_o(b_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    // Monitors: compare the head whenever it is presented, retire on handshake.
    always @(negedge clk) begin
        if (rst_n && a_out_valid) begin
            if (q_a.size() == 0) begin
                n_total++;
                $display("FAIL a_unexpected: out_valid=1 with no entry expected");
            end else begin
                check("a_imm", a_imm, q_a[0].imm);
                check("a_tag", a_tag_o, q_a[0].tag);
                check("a_err", 64'(a_err), 64'(q_a[0].err));
                if (a_out_ready) void'(q_a.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_out_valid) begin
            if (q_b.size() == 0) begin
                n_total++;
                $display("FAIL b_unexpected: out_valid=1 with no entry expected");
            end else begin
                check("b_imm", 64'(b_imm), q_b[0].imm);
                check("b_tag", b_tag_o, q_b[0].tag);
                check("b_err", 64'(b_err), 64'(q_b[0].err));
                if (b_out_ready) void'(q_b.pop_front());
            end
        end
    end

    task automatic push(input bit to_b, input logic [31:0] instr, input immediate_type_e t,
                        input logic [63:0] tag, input logic [63:0] e_imm, input logic e_err);
        exp_t e;
        bit   acc;
        e.imm = e_imm;
        e.tag = tag;
        e.err = e_err;
        acc   = 1'b0;
        if (to_b) begin
            b_instr = instr; b_type = t; b_tag = tag; b_in_valid = 1'b1;
        end else begin
            a_instr = instr; a_type = t; a_tag = tag; a_in_valid = 1'b1;
        end
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            acc = to_b ? b_in_ready : a_in_ready;
            @(posedge clk);
            #1;
        end
        if (to_b) b_in_valid = 1'b0;
        else      a_in_valid = 1'b0;
        if (!acc) begin
            n_total++;
            $display("FAIL push_timeout: in_ready=0 for 50 cycles, required 1");
        end else if (to_b) q_b.push_back(e);
        else q_a.push_back(e);
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && (q_a.size() != 0 || q_b.size() != 0); n++) @(posedge clk);
        #1;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            n_total++;
            $display("FAIL drain_timeout: %0d/%0d entries outstanding, required 0", q_a.size(), q_b.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        a_flush = 0; a_in_valid = 0; a_out_ready = 0; a_instr = '0; a_type = IMM_TYPE_NONE; a_tag = '0;
        b_flush = 0; b_in_valid = 0; b_out_ready = 0; b_instr = '0; b_type = IMM_TYPE_NONE; b_tag = '0;
        #1;
        check("rst_a_out_valid", 64'(a_out_valid), 64'd0);
        check("rst_a_in_ready",  64'(a_in_ready),  64'd1);
        check("rst_a_imm",       a_imm,            64'd0);
        check("rst_a_tag",       a_tag_o,          64'd0);
        check("rst_a_err",       64'(a_err),       64'd0);
        check("rst_a_count",     64'(a_count),     64'd0);
        check("rst_b_out_valid", 64'(b_out_valid), 64'd0);
        check("rst_b_in_ready",  64'(b_in_ready),  64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic formats on XLEN=64
        a_out_ready = 1'b1;
        push(0, 32'hFFF00093, IMM_TYPE_I, 64'h1000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        @(negedge clk);
        check("a_latency_valid", 64'(a_out_valid), 64'd1);
        @(posedge clk); #1;
        push(0, 32'h80000037, IMM_TYPE_U, 64'h1004, 64'hFFFF_FFFF_8000_0000, 1'b0);
        push(0, 32'hFE000EE3, IMM_TYPE_B, 64'h1008, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        drain();

        // Back-pressure: two fill, third held until the consumer drains
        a_out_ready = 1'b0;
        push(0, 32'hFFF00093, IMM_TYPE_I, 64'h30, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        push(0, 32'h80000037, IMM_TYPE_U, 64'h31, 64'hFFFF_FFFF_8000_0000, 1'b0);
        a_instr = 32'hFE000EE3; a_type = IMM_TYPE_B; a_tag = 64'h32; a_in_valid = 1'b1;
        @(negedge clk);
        check("full_in_ready", 64'(a_in_ready), 64'd0);
        check("full_count",    64'(a_count),    64'd2);
        @(posedge clk); #1;
        @(negedge clk);
        check("held_in_ready", 64'(a_in_ready), 64'd0);
        check("held_count",    64'(a_count),    64'd2);
        @(posedge clk); #1;
        a_out_ready = 1'b1;
        push(0, 32'hFE000EE3, IMM_TYPE_B, 64'h32, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        drain();

        // Flush of a full FIFO with a push pending
        a_out_ready = 1'b0;
        push(0, 32'h00A12423, IMM_TYPE_S, 64'h40, 64'd8, 1'b0);
        push(0, 32'hFE112E23, IMM_TYPE_S, 64'h41, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        a_instr = 32'h0080006F; a_type = IMM_TYPE_J; a_tag = 64'h42; a_in_valid = 1'b1; a_flush = 1'b1;
        @(posedge clk); #1;
        a_flush = 1'b0; a_in_valid = 1'b0;
        q_a.delete();
        @(negedge clk);
        check("flush_full_count", 64'(a_count),     64'd0);
        check("flush_full_valid", 64'(a_out_valid), 64'd0);
        check("flush_full_ready", 64'(a_in_ready),  64'd1);

        // Flush with one entry, push accepted-able and pop both requested: flush wins
        @(posedge clk); #1;
        push(0, 32'h0080006F, IMM_TYPE_J, 64'h50, 64'd8, 1'b0);
        a_instr = 32'hFFF00093; a_type = IMM_TYPE_I; a_tag = 64'h51; a_in_valid = 1'b1;
        a_flush = 1'b1; a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_flush = 1'b0; a_in_valid = 1'b0;
        q_a.delete();
        @(negedge clk);
        check("flush_one_count", 64'(a_count), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("flush_idle_count", 64'(a_count),     64'd0);
        check("flush_idle_valid", 64'(a_out_valid), 64'd0);
        @(posedge clk); #1;
        push(0, 32'hFE112E23, IMM_TYPE_S, 64'h52, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        drain();

        // XLEN=32 shift amounts and sign extension
        b_out_ready = 1'b1;
        push(1, 32'h02009093, IMM_TYPE_ISHIFT, 64'h2000, 64'd0, 1'b1);
        push(1, 32'h01F09093, IMM_TYPE_ISHIFT, 64'h2004, 64'd31, 1'b0);
        push(1, 32'hFFF00093, IMM_TYPE_I, 64'h2008, 64'h0000_0000_FFFF_FFFF, 1'b0);
        push(1, 32'h80000037, IMM_TYPE_U, 64'h200C, 64'h0000_0000_8000_0000, 1'b0);
        drain();

        // Reset mid-stream with one entry held
        a_out_ready = 1'b0;
        push(0, 32'hFFDFF06F, IMM_TYPE_J, 64'h60, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        @(negedge clk);
        check("pre_rst_count", 64'(a_count), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(a_out_valid), 64'd0);
        check("mid_rst_in_ready",  64'(a_in_ready),  64'd1);
        check("mid_rst_imm",       a_imm,            64'd0);
        check("mid_rst_tag",       a_tag_o,          64'd0);
        check("mid_rst_err",       64'(a_err),       64'd0);
        check("mid_rst_count",     64'(a_count),     64'd0);
        q_a.delete();
        q_b.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Remaining encodings on XLEN=64
        a_out_ready = 1'b1;
        push(0, 32'hFFFFFFFF, IMM_TYPE_NONE, 64'h70, 64'd0, 1'b0);
        push(0, 32'h00A12423, IMM_TYPE_S, 64'h71, 64'd8, 1'b0);
        push(0, 32'h0080006F, IMM_TYPE_J, 64'h72, 64'd8, 1'b0);
        push(0, 32'hFFDFF06F, IMM_TYPE_J, 64'h73, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        push(0, 32'h02009093, IMM_TYPE_ISHIFT, 64'h74, 64'd32, 1'b0);
`ifdef IMM_GEN_ZIMM_EN
        push(0, 32'h340AD073, immediate_type_e'(3'd7), 64'h75, 64'h15, 1'b0);
`else
        push(0, 32'h340AD073, immediate_type_e'(3'd7), 64'h75, 64'd0, 1'b1);
`endif
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
